// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Round-robin writeback arbiter for three execution units (ALU, LSU, MUL)
//   sharing one register-file write port, combined with a pending-write
//   scoreboard that flags read-after-write hazards for the decode stage.
//
// Ports
//   clk, rst                      : single clock, synchronous active-high reset
//   IssueValid, IssueAddress      : instruction issued with destination register
//   ReqValidN/ReqAddressN/ReqDataN: writeback requests (N = 0 ALU, 1 LSU, 2 MUL)
//   ReqReadyN                     : grant to requester N (combinational)
//   WriteData/WriteAddress/RegWriteEn : register-file write port (combinational)
//   GrantId                       : granted requester index, 3 = no grant
//   ReadAddress1/2, Hazard1/2     : decode source registers and their hazard flags
//   Pending                       : scoreboard vector, bit N = write outstanding
//   StallCount                    : saturating count of cycles with a waiting request
// ---------------------------------------------------------------------------
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        IssueValid,
    input  logic [4:0]  IssueAddress,
    input  logic        ReqValid0,
    input  logic        ReqValid1,
    input  logic        ReqValid2,
    input  logic [4:0]  ReqAddress0,
    input  logic [4:0]  ReqAddress1,
    input  logic [4:0]  ReqAddress2,
    input  logic [31:0] ReqData0,
    input  logic [31:0] ReqData1,
    input  logic [31:0] ReqData2,
    output logic        ReqReady0,
    output logic        ReqReady1,
    output logic        ReqReady2,
    output logic [31:0] WriteData,
    output logic [4:0]  WriteAddress,
    output logic        RegWriteEn,
    output logic [1:0]  GrantId,
    input  logic [4:0]  ReadAddress1,
    input  logic [4:0]  ReadAddress2,
    output logic        Hazard1,
    output logic        Hazard2,
    output logic [31:0] Pending,
    output logic [15:0] StallCount
);

    localparam logic [1:0] NO_GRANT = 2'd3;

    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0] pending_q, pending_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic [2:0]  req_valid_s;
    logic [2:0]  req_ready_s;
    logic [1:0]  grant_id_s;
    logic        transfer_s;
    logic        stall_s;

    assign req_valid_s = {ReqValid2, ReqValid1, ReqValid0};

    // Round-robin pick: first valid requester starting at rr_ptr_q; reset masks all grants.
    always_comb begin
        grant_id_s = NO_GRANT;
        if (rst) begin
            grant_id_s = NO_GRANT;
        end else begin
            case (rr_ptr_q)
                2'd1: begin
                    if (req_valid_s[1])      grant_id_s = 2'd1;
                    else if (req_valid_s[2]) grant_id_s = 2'd2;
                    else if (req_valid_s[0]) grant_id_s = 2'd0;
                    else                     grant_id_s = NO_GRANT;
                end
                2'd2: begin
                    if (req_valid_s[2])      grant_id_s = 2'd2;
                    else if (req_valid_s[0]) grant_id_s = 2'd0;
                    else if (req_valid_s[1]) grant_id_s = 2'd1;
                    else                     grant_id_s = NO_GRANT;
                end
                default: begin
                    // Pointer value 3 never occurs; treat it like 0.
                    if (req_valid_s[0])      grant_id_s = 2'd0;
                    else if (req_valid_s[1]) grant_id_s = 2'd1;
                    else if (req_valid_s[2]) grant_id_s = 2'd2;
                    else                     grant_id_s = NO_GRANT;
                end
            endcase
        end
    end

    // Write-port steering from the granted requester; zeros when nothing is granted.
    always_comb begin
        req_ready_s  = 3'b000;
        WriteAddress = 5'd0;
        WriteData    = 32'd0;
        case (grant_id_s)
            2'd0: begin
                req_ready_s  = 3'b001;
                WriteAddress = ReqAddress0;
                WriteData    = ReqData0;
            end
            2'd1: begin
                req_ready_s  = 3'b010;
                WriteAddress = ReqAddress1;
                WriteData    = ReqData1;
            end
            2'd2: begin
                req_ready_s  = 3'b100;
                WriteAddress = ReqAddress2;
                WriteData    = ReqData2;
            end
            default: begin
                req_ready_s  = 3'b000;
                WriteAddress = 5'd0;
                WriteData    = 32'd0;
            end
        endcase
    end

    // A granted requester is always valid, so any grant is a transfer.
    assign transfer_s = (grant_id_s != NO_GRANT);
    // x0 writes are accepted but never reach the register file.
    assign RegWriteEn = transfer_s && (WriteAddress != 5'd0);
    assign stall_s    = (!rst) && ((req_valid_s & ~req_ready_s) != 3'b000);

    // Next-state for pointer, scoreboard and stall counter.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        pending_d     = pending_q;
        stall_count_d = stall_count_q;
        if (transfer_s) begin
            rr_ptr_d = (grant_id_s == 2'd2) ? 2'd0 : (grant_id_s + 2'd1);
            pending_d[WriteAddress] = 1'b0;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        // Applied after the clear so a coincident issue keeps the bit set.
        if (IssueValid && (IssueAddress != 5'd0)) begin
            pending_d[IssueAddress] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;
        if (stall_s && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= 2'd0;
            pending_q     <= 32'd0;
            stall_count_q <= 16'd0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            pending_q     <= pending_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ReqReady0  = req_ready_s[0];
    assign ReqReady1  = req_ready_s[1];
    assign ReqReady2  = req_ready_s[2];
    assign GrantId    = grant_id_s;
    assign Pending    = pending_q;
    assign StallCount = stall_count_q;
    assign Hazard1    = pending_q[ReadAddress1];
    assign Hazard2    = pending_q[ReadAddress2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        IssueValid;
    logic [4:0]  IssueAddress;
    logic        ReqValid0, ReqValid1, ReqValid2;
    logic [4:0]  ReqAddress0, ReqAddress1, ReqAddress2;
    logic [31:0] ReqData0, ReqData1, ReqData2;
    logic        ReqReady0, ReqReady1, ReqReady2;
    logic [31:0] WriteData;
    logic [4:0]  WriteAddress;
    logic        RegWriteEn;
    logic [1:0]  GrantId;
    logic [4:0]  ReadAddress1, ReadAddress2;
    logic        Hazard1, Hazard2;
    logic [31:0] Pending;
    logic [15:0] StallCount;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .IssueValid(IssueValid), .IssueAddress(IssueAddress),
        .ReqValid0(ReqValid0), .ReqValid1(ReqValid1), .ReqValid2(ReqValid2),
        .ReqAddress0(ReqAddress0), .ReqAddress1(ReqAddress1), .ReqAddress2(ReqAddress2),
        .ReqData0(ReqData0), .ReqData1(ReqData1), .ReqData2(ReqData2),
        .ReqReady0(ReqReady0), .ReqReady1(ReqReady1), .ReqReady2(ReqReady2),
        .WriteData(WriteData), .WriteAddress(WriteAddress), .RegWriteEn(RegWriteEn),
        .GrantId(GrantId),
        .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2),
        .Hazard1(Hazard1), .Hazard2(Hazard2),
        .Pending(Pending), .StallCount(StallCount)
    );

    // One cycle of stimulus plus the hand-written expected grant and write enable.
    // Request data is base+0 / base+1 / base+2 for requesters 0 / 1 / 2.
    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  ia;
        logic [2:0]  rv;
        logic [4:0]  ra0, ra1, ra2;
        logic [4:0]  rd1, rd2;
        logic [31:0] base;
        logic [1:0]  exp_gid;
        logic        exp_en;
    } vec_t;

    typedef struct {
        logic [2:0]  ready;
        logic [31:0] wd;
        logic [4:0]  wa;
        logic        en;
        logic [1:0]  gid;
        logic [31:0] pend;
        logic        h1, h2;
        logic [15:0] stall;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state
    logic [1:0]  m_rr;
    logic [31:0] m_pend;
    logic [15:0] m_stall;

    vec_t tbl[15];

    function automatic vec_t mk(input logic r, input logic iv, input logic [4:0] ia,
                                input logic [2:0] rv, input logic [4:0] a0, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [4:0] rd1, input logic [4:0] rd2,
                                input logic [31:0] base, input logic [1:0] gid, input logic en);
        vec_t v;
        v.rst = r; v.iv = iv; v.ia = ia; v.rv = rv;
        v.ra0 = a0; v.ra1 = a1; v.ra2 = a2; v.rd1 = rd1; v.rd2 = rd2;
        v.base = base; v.exp_gid = gid; v.exp_en = en;
        return v;
    endfunction

    function automatic logic [1:0] m_arb(input logic [2:0] v, input logic [1:0] rr);
        for (int i = 0; i < 3; i++) begin
            int k;
            k = (int'(rr) + i) % 3;
            if (v[k]) return 2'(k);
        end
        return 2'd3;
    endfunction

    function automatic logic [4:0] addr_of(input vec_t v, input logic [1:0] k);
        case (k)
            2'd0:    return v.ra0;
            2'd1:    return v.ra1;
            2'd2:    return v.ra2;
            default: return 5'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle (entered just after a negedge), compare mid-cycle, advance the model.
    task automatic step(input vec_t v, input bit check);
        exp_t       e;
        logic [1:0] g;
        rst          = v.rst;
        IssueValid   = v.iv;
        IssueAddress = v.ia;
        ReqValid0    = v.rv[0];
        ReqValid1    = v.rv[1];
        ReqValid2    = v.rv[2];
        ReqAddress0  = v.ra0;
        ReqAddress1  = v.ra1;
        ReqAddress2  = v.ra2;
        ReqData0     = v.base;
        ReqData1     = v.base + 32'd1;
        ReqData2     = v.base + 32'd2;
        ReadAddress1 = v.rd1;
        ReadAddress2 = v.rd2;
        g = v.rst ? 2'd3 : m_arb(v.rv, m_rr);
        if (check) begin
            e.gid   = v.exp_gid;
            e.en    = v.exp_en;
            e.ready = (v.exp_gid == 2'd3) ? 3'b000 : (3'b001 << v.exp_gid);
            e.wa    = addr_of(v, v.exp_gid);
            e.wd    = (v.exp_gid == 2'd3) ? 32'd0 : (v.base + 32'(v.exp_gid));
            e.pend  = m_pend;
            e.h1    = m_pend[v.rd1];
            e.h2    = m_pend[v.rd2];
            e.stall = m_stall;
            sb_q.push_back(e);
        end
        #2;
        if (check) begin
            e = sb_q.pop_front();
            chk("ready",      32'({ReqReady2, ReqReady1, ReqReady0}), 32'(e.ready));
            chk("gid",        32'(GrantId),      32'(e.gid));
            chk("wen",        32'(RegWriteEn),   32'(e.en));
            chk("waddr",      32'(WriteAddress), 32'(e.wa));
            chk("wdata",      WriteData,         e.wd);
            chk("pending",    Pending,           e.pend);
            chk("hazard1",    32'(Hazard1),      32'(e.h1));
            chk("hazard2",    32'(Hazard2),      32'(e.h2));
            chk("stallcount", 32'(StallCount),   32'(e.stall));
        end
        if (v.rst) begin
            m_rr = 2'd0; m_pend = 32'd0; m_stall = 16'd0;
        end else begin
            if (g != 2'd3) begin
                m_rr = (g == 2'd2) ? 2'd0 : g + 2'd1;
                m_pend[addr_of(v, g)] = 1'b0;
            end
            if (v.iv && v.ia != 5'd0) m_pend[v.ia] = 1'b1;
            if ((v.rv & ~((g == 2'd3) ? 3'b000 : (3'b001 << g))) != 3'b000 && m_stall != 16'hFFFF)
                m_stall = m_stall + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        m_rr = 2'd0; m_pend = 32'd0; m_stall = 16'd0;
        //           rst iv  ia     rv      a0     a1     a2     rd1    rd2    base           gid   en
        tbl[0]  = mk(1, 0, 5'd0,  3'b111, 5'd5,  5'd6,  5'd7,  5'd0,  5'd0,  32'h1000_0000, 2'd3, 0);
        tbl[1]  = mk(0, 0, 5'd0,  3'b111, 5'd5,  5'd6,  5'd7,  5'd0,  5'd0,  32'h1000_0100, 2'd0, 1);
        tbl[2]  = mk(0, 0, 5'd0,  3'b111, 5'd5,  5'd6,  5'd7,  5'd0,  5'd0,  32'h1000_0200, 2'd1, 1);
        tbl[3]  = mk(0, 0, 5'd0,  3'b111, 5'd5,  5'd6,  5'd7,  5'd0,  5'd0,  32'h1000_0300, 2'd2, 1);
        tbl[4]  = mk(0, 1, 5'd10, 3'b000, 5'd0,  5'd0,  5'd0,  5'd10, 5'd0,  32'h2000_0000, 2'd3, 0);
        tbl[5]  = mk(0, 0, 5'd0,  3'b010, 5'd0,  5'd10, 5'd0,  5'd10, 5'd0,  32'h2000_0100, 2'd1, 1);
        tbl[6]  = mk(0, 0, 5'd0,  3'b000, 5'd0,  5'd0,  5'd0,  5'd10, 5'd0,  32'h2000_0200, 2'd3, 0);
        tbl[7]  = mk(0, 1, 5'd12, 3'b001, 5'd12, 5'd0,  5'd0,  5'd0,  5'd12, 32'h3000_0000, 2'd0, 1);
        tbl[8]  = mk(0, 0, 5'd0,  3'b000, 5'd0,  5'd0,  5'd0,  5'd0,  5'd12, 32'h3000_0100, 2'd3, 0);
        // base chosen so the MUL data (base+2) is 32'hDEADBEEF
        tbl[9]  = mk(0, 1, 5'd0,  3'b100, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  32'hDEAD_BEED, 2'd2, 0);
        tbl[10] = mk(0, 0, 5'd0,  3'b000, 5'd0,  5'd0,  5'd0,  5'd0,  5'd12, 32'h4000_0000, 2'd3, 0);
        tbl[11] = mk(0, 0, 5'd0,  3'b110, 5'd5,  5'd6,  5'd7,  5'd0,  5'd0,  32'h4000_0100, 2'd1, 1);
        tbl[12] = mk(0, 0, 5'd0,  3'b011, 5'd5,  5'd6,  5'd7,  5'd0,  5'd0,  32'h4000_0200, 2'd0, 1);
        tbl[13] = mk(0, 0, 5'd0,  3'b101, 5'd5,  5'd6,  5'd7,  5'd0,  5'd0,  32'h4000_0300, 2'd2, 1);
        tbl[14] = mk(0, 0, 5'd0,  3'b001, 5'd20, 5'd0,  5'd0,  5'd0,  5'd0,  32'h5000_0000, 2'd0, 1);

        @(negedge clk);
        step(mk(1, 0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 2'd3, 0), 1'b0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i], 1'b1);
            if (i == 3) chk("rr_stall3", 32'(StallCount), 32'd3);
            if (i == 9) chk("x0_ready2", 32'(ReqReady2), 32'd1);
        end

        // Saturation: reset, then 65534 cycles with all three requesting (each cycle stalls two).
        step(mk(1, 0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 2'd3, 0), 1'b0);
        for (int i = 0; i < 65534; i++)
            step(mk(0, 0, 5'd0, 3'b111, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 32'h6000_0000, 2'd3, 0), 1'b0);
        chk("stall_fffe", 32'(StallCount), 32'h0000_FFFE);
        // 65534 grants leave the pointer at 65534 mod 3 = 2
        step(mk(0, 0, 5'd0, 3'b111, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 32'h7000_0000, 2'd2, 1), 1'b1);
        step(mk(0, 0, 5'd0, 3'b111, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 32'h7000_0100, 2'd0, 1), 1'b1);
        step(mk(0, 0, 5'd0, 3'b111, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 32'h7000_0200, 2'd1, 1), 1'b1);
        chk("stall_sat", 32'(StallCount), 32'h0000_FFFF);
        // Reset arrives while requests are pending: nothing granted or written.
        step(mk(1, 1, 5'd9, 3'b111, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 32'h8000_0000, 2'd3, 0), 1'b1);
        chk("rst_stall0", 32'(StallCount), 32'd0);
        chk("rst_pend0",  Pending, 32'd0);
        // First cycle after reset starts from pointer 0 with the requests re-presented.
        step(mk(0, 0, 5'd0, 3'b111, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 32'h9000_0000, 2'd0, 1), 1'b1);
        step(mk(0, 0, 5'd0, 3'b110, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 32'h9000_0100, 2'd1, 1), 1'b1);
        chk("post_rst_stall", 32'(StallCount), 32'd2);

        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
